// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, error codes
// and the access-sequencer state type.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  // Byte-enable pattern for an access of the given size at byte offset lo.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b1111;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data onto every lane it could land on, so the
  // byte enables alone select the written bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    case (sz)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load path: picks the addressed byte/halfword out of a memory
// word and sign- or zero-extends it to 32 bits. Word loads pass through.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_extend,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension of the selected field
  always_comb begin
    byte_sel = mem_rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    result   = mem_rdata;
    case (size)
      SZ_BYTE: result = {{24{byte_sel[7] & ~zero_extend}}, byte_sel};
      SZ_HALF: result = {{16{half_sel[15] & ~zero_extend}}, half_sel};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// Data-memory access unit: checks alignment, steers store data onto byte
// lanes, runs the request/ready handshake with a timeout, and extends loads.
module mem_align_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              zero_extend,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t            state_reg;
  logic              busy_reg, done_reg, err_reg;
  logic [1:0]        err_code_reg;
  logic [31:0]       rdata_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [3:0]        mem_be_reg;
  logic [31:0]       mem_wdata_reg;
  logic [1:0]        size_reg, addr_lo_reg;
  logic              zext_reg;
  logic [7:0]        cnt_reg;

  logic [1:0]        chk_code;
  logic              timeout_hit;
  logic [31:0]       load_result;

  // Legality of the incoming request; reserved size outranks misalignment
  always_comb begin
    chk_code = ERR_NONE;
    if (size == SZ_RSVD)
      chk_code = ERR_SIZE;
    else if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
      chk_code = ERR_MISALIGN;
  end

  // This ACCESS cycle is the TIMEOUT-th one without mem_ready
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_reg + 8'd1) == TO_LIMIT);

  load_extract u_load_extract (
    .mem_rdata   (mem_rdata),
    .addr_lo     (addr_lo_reg),
    .size        (size_reg),
    .zero_extend (zext_reg),
    .result      (load_result)
  );

  // Access sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      rdata_reg     <= 32'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 4'd0;
      mem_wdata_reg <= 32'd0;
      size_reg      <= SZ_BYTE;
      addr_lo_reg   <= 2'b00;
      zext_reg      <= 1'b0;
      cnt_reg       <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg     <= 1'b0;
          err_reg      <= 1'b0;
          err_code_reg <= ERR_NONE;
          if (start) begin
            busy_reg <= 1'b1;
            if (chk_code != ERR_NONE) begin
              // Illegal request never reaches memory
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              err_reg      <= 1'b1;
              err_code_reg <= chk_code;
            end else begin
              state_reg     <= ACCESS;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= is_store;
              mem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_reg    <= lane_be(size, addr[1:0]);
              mem_wdata_reg <= lane_wdata(size, wdata);
              size_reg      <= size;
              addr_lo_reg   <= addr[1:0];
              zext_reg      <= zero_extend;
              cnt_reg       <= 8'd0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            // Ready beats a coincident timeout
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            done_reg    <= 1'b1;
            err_reg     <= 1'b0;
            err_code_reg <= ERR_NONE;
            if (!mem_we_reg)
              rdata_reg <= load_result;
          end else if (timeout_hit) begin
            state_reg    <= DONE;
            mem_req_reg  <= 1'b0;
            done_reg     <= 1'b1;
            err_reg      <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
          err_reg      <= 1'b0;
          err_code_reg <= ERR_NONE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign rdata     = rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Data-memory access unit between the datapath and data memory; the narrowing and lane-steering counterpart of the immediate sign/zero extender.
- Stores: steers a byte or halfword from a 32-bit register value onto the correct byte lanes and generates byte enables.
- Loads: extracts the addressed byte or halfword, then sign- or zero-extends it to 32 bits.
- Handles a multi-cycle memory handshake with misalignment and timeout detection.

Parameters:
ADDR_W, 32, address width in bits
TIMEOUT, 255, maximum wait cycles for mem_ready; 0 disables the timeout; 8-bit counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
is_store  input  1  1=store, 0=load
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
zero_extend  input  1  loads only: 1=zero-extend, 0=sign-extend
addr  input  ADDR_W  byte address
wdata  input  32  store data; low byte/half used for narrow stores
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1=access failed
err_code  output  2  00 none, 01 misaligned, 10 timeout, 11 bad size
rdata  output  32  extended load result; valid from done onward
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  1=write
mem_addr  output  ADDR_W  word-aligned address, addr with [1:0]=00
mem_be  output  4  byte enables; bit i = bits 8i+7:8i (little-endian lanes)
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  memory completes the access in this cycle
mem_rdata  input  32  read data, valid when mem_ready=1

Behaviour:
- Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; err_code=00; rdata=0; mem_addr=0; mem_be=0; mem_wdata=0; timeout counter=0.
- Reset mid-access: mem_req drops at the next edge; no done pulse is produced; the in-flight access is abandoned.
- States:
  - IDLE -> ACCESS on start when the access is legal.
  - IDLE -> DONE on start when it is illegal; no mem_req is issued.
  - ACCESS -> DONE on mem_ready, or on timeout.
  - DONE -> IDLE unconditionally.
- Legality checks, in priority order:
  - size=11 -> code 11.
  - halfword with addr[0]=1, or word with addr[1:0]!=00 -> code 01.
- All request fields (mem_we, mem_addr, mem_be, mem_wdata) are registered at start acceptance and held constant through ACCESS.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << (2*addr[1])
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- mem_be is driven on loads as well.
- Load extraction at mem_ready:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Bit 7 or bit 15 is replicated upward if zero_extend=0; zeros are filled otherwise.
  - Word loads pass through unchanged.
  - rdata updates in the same edge that enters DONE.
- Stores and errored accesses leave rdata unchanged.
- Latency:
  - start accepted at edge T -> mem_req high after T.
  - mem_ready sampled high at edge T+k (k>=1) -> done high for the cycle after T+k.
  - Minimum start-to-done: 2 edges. Misaligned/bad size: done after 1 edge.
- Timeout:
  - The counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready.
  - When it reaches TIMEOUT (TIMEOUT!=0): go to DONE with err=1, code 10, and drop mem_req.
  - mem_ready in the same cycle as the timeout wins: normal completion.
- busy is 1 in ACCESS and DONE. start while busy=1 is ignored; a start in the DONE cycle is ignored.
- err and err_code are valid only while done=1 and are cleared in IDLE.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - err codes ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_SIZE
  - state enum IDLE/ACCESS/DONE
- One combinational sub-module load_extract (inputs: mem_rdata, addr[1:0], size, zero_extend; output: 32-bit result). It is independently testable and reuses the extender convention.

Test Plan:
- Load byte, addr=0x1003, mem_rdata=0x8F2040C0, zero_extend=0, mem_ready on 1st ACCESS cycle -> mem_addr=0x1000, mem_be=1000, rdata=0xFFFFFF8F, done 2 cycles after start.
- Same load with zero_extend=1 -> rdata=0x0000008F; load half addr=0x1002, zero_extend=0 -> rdata=0xFFFF8F20.
- Store half addr=0x2002, wdata=0x12348FC0 -> mem_we=1, mem_be=1100, mem_wdata=0x8FC08FC0; rdata unchanged.
- Load word addr=0x2001 -> no mem_req; done next cycle, err=1, err_code=01. Size=11 -> err_code=11.
- TIMEOUT=4, mem_ready held 0 -> mem_req for 4 cycles, then done, err=1, err_code=10. mem_ready in the 4th cycle instead -> err=0.
- rst asserted during ACCESS -> next cycle mem_req=0, busy=0, rdata=0, and no done pulse; a start during busy is ignored (one done only).
